// File: rtl/writeback_stage.sv
// Result writeback stage: byte-enable generation, reduction collapse, a small result FIFO
// toward the VRF write port, and pending-destination / completion tracking.
module writeback_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [4:0]   in_vd,
  input  logic [1:0]   in_beat,
  input  logic         in_last,
  input  logic         in_reduction,
  input  logic [1:0]   in_vsew,
  input  logic [4:0]   in_vl,
  output logic         wr_valid,
  input  logic         wr_ready,
  output logic [4:0]   wr_vd,
  output logic [1:0]   wr_beat,
  output logic [127:0] wr_data,
  output logic [15:0]  wr_be,
  output logic         pend_valid,
  output logic [4:0]   pend_vd,
  output logic         wb_done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  typedef enum logic {StIdle, StBusy} state_e;

  logic [4:0]   r_vd   [DEPTH];
  logic [1:0]   r_beat [DEPTH];
  logic [127:0] r_data [DEPTH];
  logic [15:0]  r_be   [DEPTH];
  logic         r_last [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  state_e        r_state, w_state_next;
  logic [4:0]    r_pend_vd;
  logic          r_done;

  logic        w_full, w_empty, w_in_ready, w_accept, w_push;
  logic        w_head_zero, w_pop, w_pop_last;
  logic [15:0] w_be;
  logic [5:0]  w_elem;

  assign w_full      = (r_count == DepthCnt);
  assign w_empty     = (r_count == '0);
  assign w_in_ready  = ~reset & ~w_full;
  assign w_accept    = in_valid & w_in_ready;
  // Intermediate reduction beats are absorbed; only the final one is written.
  assign w_push      = w_accept & ~(in_reduction & ~in_last);
  assign w_head_zero = (r_be[r_rptr] == '0);
  assign w_pop       = ~w_empty & (w_head_zero | wr_ready);
  assign w_pop_last  = w_pop & r_last[r_rptr];

  // Element index of byte b is ({beat, b} >> vsew); enabled while below vl.
  always_comb begin
    w_be   = '0;
    w_elem = '0;
    if (in_vl != '0) begin
      if (in_reduction) begin
        unique case (in_vsew)
          2'd0:    w_be = 16'h0001;
          2'd1:    w_be = 16'h0003;
          2'd2:    w_be = 16'h000F;
          default: w_be = '0;
        endcase
      end else if (in_vsew != 2'd3) begin
        for (int b = 0; b < 16; b++) begin
          w_elem  = {in_beat, 4'(b)} >> in_vsew;
          w_be[b] = (w_elem < {1'b0, in_vl});
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_vd[i]   <= '0;
        r_beat[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
        r_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_vd[r_wptr]   <= in_vd;
        r_beat[r_wptr] <= in_reduction ? 2'd0 : in_beat;
        r_data[r_wptr] <= in_data;
        r_be[r_wptr]   <= w_be;
        r_last[r_wptr] <= in_last;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pend_vd <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_pop_last;
      if (w_accept && (r_state == StIdle || w_pop_last)) r_pend_vd <= in_vd;
    end
  end

  // A new instruction's first beat arriving as the old last retires keeps us busy.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StBusy;
      StBusy:  if (w_pop_last && !w_accept) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready   = w_in_ready;
    wr_valid   = ~reset & ~w_empty & ~w_head_zero;
    wr_vd      = reset ? '0 : r_vd[r_rptr];
    wr_beat    = reset ? '0 : r_beat[r_rptr];
    wr_data    = reset ? '0 : r_data[r_rptr];
    wr_be      = reset ? '0 : r_be[r_rptr];
    pend_valid = ~reset & (r_state == StBusy);
    pend_vd    = reset ? '0 : r_pend_vd;
    wb_done    = ~reset & r_done;
  end

endmodule
